// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath: steps each
// instruction through fetch/decode/execute/memory/writeback and drives all selects.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE    | register read, branch target precomputed into ALUOut
// MEM_ADDR  | effective address Da + sign-extended imm
// MEM_READ  | data load, waits on mem_ready
// MEM_WB    | load data written to Rt
// MEM_WRITE | data store, waits on mem_ready, retires on completion
// R_EXEC    | Da op Db for ADD/SUB/SLT
// ALU_WB    | ALUOut written to Rd (R-type) or Rt (I-type)
// I_EXEC    | Da op extended imm for ADDI/XORI
// BRANCH    | compare Da/Db, conditional PC <= ALUOut
// JUMP      | PC <= {PC[31:28], target, 00}
// JAL       | JUMP plus $31 <= PC
// JR        | PC <= Da
// TRAP      | illegal instruction, parked until reset
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_zero,
  output logic [2:0]  alu_cmd,
  output logic [1:0]  pc_source,
  output logic        retired,
  output logic [31:0] retire_count,
  output logic        trap
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_I_EXEC    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_t state, state_nxt;
  logic   is_rtype;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      is_rtype     <= 1'b0;
      retire_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        is_rtype <= (opcode == OP_RTYPE);
      if (retired)
        retire_count <= retire_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_nxt = S_I_EXEC;
          OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
          OP_J:            state_nxt = S_JUMP;
          OP_JAL:          state_nxt = S_JAL;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT: state_nxt = S_R_EXEC;
              FN_JR:                  state_nxt = S_JR;
              default:                state_nxt = S_TRAP;
            endcase
          end
          default:         state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC,
      S_I_EXEC:    state_nxt = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP,
      S_JAL,
      S_JR:        state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      // unused encodings are treated as a corrupted state and trapped
      default:     state_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_cmd    = ALU_ADD;
    pc_source  = 2'b00;
    retired    = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retired    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retired   = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_cmd = ALU_SUB;
          FN_SLT:  alu_cmd = ALU_SLT;
          default: alu_cmd = ALU_ADD;
        endcase
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_XORI) begin
          alu_cmd  = ALU_XOR;
          ext_zero = 1'b1;
        end
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype ? 2'b01 : 2'b00;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cmd   = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        retired   = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retired   = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        retired    = 1'b1;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        retired   = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of per-instruction vectors, hand-written
// stall/reset/trap sequences, and randomized handshakes against a phase model.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic        alu_src_a, ext_zero, retired, trap;
  logic [2:0]  alu_cmd;
  logic [31:0] retire_count;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_cmd(alu_cmd),
    .pc_source(pc_source), .retired(retired), .retire_count(retire_count),
    .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_cmd;
    logic [1:0] pc_source;
    logic       retired, trap;
  } out_t;

  // c3: {alu_src_a, alu_src_b, alu_cmd, ext_zero} in the third cycle
  // ret: {pc_write, reg_write, reg_dst, mem_to_reg, pc_source, mem_write} in the retire cycle
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [6:0] c3;
    logic [8:0] ret;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cnt    = 0;
  out_t hist [64];
  bit   rdy_pat [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t snap();
    out_t o;
    o = '{pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
          alu_src_a, alu_src_b, ext_zero, alu_cmd, pc_source, retired, trap};
    return o;
  endfunction

  function automatic out_t fetch_outs(input logic rdy);
    out_t e;
    e = '0;
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    e.ir_write  = rdy;
    e.pc_write  = rdy;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // runs one instruction from FETCH, mem_ready per cycle from rdy_pat; lat=0 if no retire
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, output int lat);
    lat = 0;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int c = 0; c < 64; c++) begin
      mem_ready = rdy_pat[c];
      #1;
      hist[c] = snap();
      step();
      if (hist[c].retired) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  // expected cycles from instruction phases: memory phases last until a ready cycle
  function automatic void model(input int cls, output int lat, output int f_cyc, output int d_cyc);
    int i;
    i = 0;
    while (!rdy_pat[i]) i++;
    i++;
    f_cyc = i;
    i++;
    d_cyc = 0;
    case (cls)
      0: begin
        i++;
        while (!rdy_pat[i]) begin i++; d_cyc++; end
        i++; d_cyc++;
        i++;
      end
      1: begin
        i++;
        while (!rdy_pat[i]) begin i++; d_cyc++; end
        i++; d_cyc++;
      end
      2, 3: i += 2;
      default: i += 1;
    endcase
    lat = i;
  endfunction

  vec_t tbl [15];
  logic [5:0] op_l  [12] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] fn_l  [12] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  int         cls_l [12] = '{0, 1, 2, 2, 2, 7, 3, 3, 4, 4, 5, 6};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, n, n2, e_lat, f_cyc, d_cyc, sel, taken, e_rw;
    int   n_pcw, n_rw, n_mr, n_mw, n_io, n_ir;
    out_t h;

    tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 7'b1_10_000_0, 9'b0_1_00_01_00_0};
    tbl[1]  = '{6'h2B, 6'h00, 1'b0, 4, 7'b1_10_000_0, 9'b0_0_00_00_00_1};
    tbl[2]  = '{6'h00, 6'h20, 1'b0, 4, 7'b1_00_000_0, 9'b0_1_01_00_00_0};
    tbl[3]  = '{6'h00, 6'h22, 1'b1, 4, 7'b1_00_001_0, 9'b0_1_01_00_00_0};
    tbl[4]  = '{6'h00, 6'h2A, 1'b0, 4, 7'b1_00_011_0, 9'b0_1_01_00_00_0};
    tbl[5]  = '{6'h08, 6'h00, 1'b0, 4, 7'b1_10_000_0, 9'b0_1_00_00_00_0};
    tbl[6]  = '{6'h0E, 6'h00, 1'b0, 4, 7'b1_10_010_1, 9'b0_1_00_00_00_0};
    tbl[7]  = '{6'h04, 6'h00, 1'b1, 3, 7'b1_00_001_0, 9'b1_0_00_00_01_0};
    tbl[8]  = '{6'h04, 6'h00, 1'b0, 3, 7'b1_00_001_0, 9'b0_0_00_00_01_0};
    tbl[9]  = '{6'h05, 6'h00, 1'b1, 3, 7'b1_00_001_0, 9'b0_0_00_00_01_0};
    tbl[10] = '{6'h05, 6'h00, 1'b0, 3, 7'b1_00_001_0, 9'b1_0_00_00_01_0};
    tbl[11] = '{6'h02, 6'h00, 1'b0, 3, 7'b0_00_000_0, 9'b1_0_00_00_10_0};
    tbl[12] = '{6'h03, 6'h00, 1'b0, 3, 7'b0_00_000_0, 9'b1_1_10_10_10_0};
    tbl[13] = '{6'h00, 6'h08, 1'b0, 3, 7'b0_00_000_0, 9'b1_0_00_00_11_0};
    tbl[14] = '{6'h00, 6'h20, 1'b0, 4, 7'b1_00_000_0, 9'b0_1_01_00_00_0};

    reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    #2;
    check("reset_outs_rdy0", 32'(snap()), 32'(fetch_outs(1'b0)));
    check("reset_count", retire_count, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("reset_outs_rdy1", 32'(snap()), 32'(fetch_outs(1'b1)));
    @(negedge clk);
    reset = 1'b0;

    foreach (rdy_pat[c]) rdy_pat[c] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      run(tbl[k].op, tbl[k].fn, tbl[k].z, lat);
      check($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
      h = hist[1];
      check($sformatf("tbl%0d_decode", k), {h.alu_src_a, h.alu_src_b, h.alu_cmd}, 6'b0_11_000);
      h = hist[2];
      check($sformatf("tbl%0d_cycle3", k), {h.alu_src_a, h.alu_src_b, h.alu_cmd, h.ext_zero}, tbl[k].c3);
      h = hist[(lat > 0) ? lat - 1 : 0];
      check($sformatf("tbl%0d_retire", k),
            {h.pc_write, h.reg_write, h.reg_dst, h.mem_to_reg, h.pc_source, h.mem_write}, tbl[k].ret);
      cnt++;
      check($sformatf("tbl%0d_count", k), retire_count, cnt);
    end

    // LW with two stalled cycles in the data read
    rdy_pat[3] = 1'b0;
    rdy_pat[4] = 1'b0;
    run(6'h23, 6'h00, 1'b0, lat);
    rdy_pat[3] = 1'b1;
    rdy_pat[4] = 1'b1;
    check("lw_stall_latency", lat, 7);
    n = 0;
    for (int c = 3; c < 6; c++) if (hist[c].mem_read && hist[c].iord && !hist[c].reg_write) n++;
    check("lw_stall_read_held", n, 3);
    n2 = 0;
    for (int c = 0; c < 7; c++) if (hist[c].reg_write) n2++;
    check("lw_stall_rw_count", n2, 1);
    check("lw_stall_rw_last", hist[6].reg_write, 1'b1);
    cnt++;
    check("lw_stall_count", retire_count, cnt);

    for (int t = 0; t < 150; t++) begin
      foreach (rdy_pat[c]) rdy_pat[c] = ($urandom_range(0, 3) != 0) || (c % 6 == 5);
      sel = $urandom_range(0, 11);
      zero = 1'($urandom_range(0, 1));
      model(cls_l[sel], e_lat, f_cyc, d_cyc);
      case (cls_l[sel])
        4: taken = ((op_l[sel] == 6'h04) == zero) ? 1 : 0;
        5, 6, 7: taken = 1;
        default: taken = 0;
      endcase
      e_rw = (cls_l[sel] == 0 || cls_l[sel] == 2 || cls_l[sel] == 3 || cls_l[sel] == 6) ? 1 : 0;
      run(op_l[sel], fn_l[sel], zero, lat);
      n_pcw = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_io = 0; n_ir = 0;
      for (int c = 0; c < lat; c++) begin
        n_pcw += int'(hist[c].pc_write);
        n_rw  += int'(hist[c].reg_write);
        n_mr  += int'(hist[c].mem_read);
        n_mw  += int'(hist[c].mem_write);
        n_io  += int'(hist[c].iord);
        n_ir  += int'(hist[c].ir_write);
      end
      check("rnd_latency", lat, e_lat);
      check("rnd_pc_writes", n_pcw, 1 + taken);
      check("rnd_reg_writes", n_rw, e_rw);
      check("rnd_mem_read_cycles", n_mr, f_cyc + ((cls_l[sel] == 0) ? d_cyc : 0));
      check("rnd_mem_write_cycles", n_mw, (cls_l[sel] == 1) ? d_cyc : 0);
      check("rnd_iord_cycles", n_io, d_cyc);
      check("rnd_ir_writes", n_ir, 1);
      cnt++;
      check("rnd_count", retire_count, cnt);
    end

    // reset during a stalled store
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    mem_ready = 1'b0;
    step();
    step();
    #1;
    check("sw_stall_strobes", {mem_write, iord, retired}, 3'b110);
    reset = 1'b1;
    #1;
    check("sw_reset_outs", 32'(snap()), 32'(fetch_outs(1'b0)));
    check("sw_reset_count", retire_count, 32'd0);
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;

    // one retire, then illegal opcode parks the controller
    foreach (rdy_pat[c]) rdy_pat[c] = 1'b1;
    run(6'h02, 6'h00, 1'b0, lat);
    cnt++;
    opcode = 6'h3F; mem_ready = 1'b1;
    step();
    step();
    n = 0; n2 = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (trap) n++;
      if (pc_write | reg_write | mem_read | mem_write | ir_write | retired) n2++;
      step();
    end
    check("trap_held", n, 20);
    check("trap_no_enables", n2, 0);
    check("trap_count_frozen", retire_count, cnt);
    reset = 1'b1;
    #1;
    check("trap_reset_clear", {trap, retire_count}, 33'd0);
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;

    // unsupported R-type funct also traps
    opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
    step();
    step();
    #1;
    check("trap_bad_funct", {trap, retired}, 2'b10);
    reset = 1'b1;
    #1;
    check("trap_bad_funct_clear", trap, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
